// File: rtl/event_arb_2d.sv
// Two-level (row, then column) round-robin arbiter for a pixel event array, with a timestamped event FIFO.
// Optional macro EVT_TS_WRAP_MARKER_EN inserts a wrap=1 marker event after each timestamp counter wrap.
module event_arb_2d #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int POL_W      = 2,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int X_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int Y_W       = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int L_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         enable_i,
    input  logic [ROWS*COLS*POL_W-1:0]   req_i,
    output logic [ROWS*COLS-1:0]         gnt_o,
    output logic                         evt_valid_o,
    input  logic                         evt_ready_i,
    output logic [X_W-1:0]               evt_x_o,
    output logic [Y_W-1:0]               evt_y_o,
    output logic [POL_W-1:0]             evt_pol_o,
    output logic [TS_W-1:0]              evt_ts_o,
    output logic                         evt_wrap_o,
    output logic [L_W-1:0]               fifo_level_o,
    output logic                         busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ROW_ARB, S_COL_GRANT, S_ROW_DONE} state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [POL_W-1:0] pol;
        logic [TS_W-1:0]  ts;
    } evt_t;

    // First requester strictly after 'last', wrapping around.
    function automatic logic [X_W-1:0] pick_row(input logic [ROWS-1:0] reqs, input logic [X_W-1:0] last);
        int   idx;
        logic found;
        pick_row = '0;
        found    = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            idx = int'(last) + 1 + i;
            if (idx >= ROWS) idx -= ROWS;
            if (!found && reqs[X_W'(idx)]) begin
                found    = 1'b1;
                pick_row = X_W'(idx);
            end
        end
    endfunction

    function automatic logic [Y_W-1:0] pick_col(input logic [COLS-1:0] reqs, input logic [Y_W-1:0] last);
        int   idx;
        logic found;
        pick_col = '0;
        found    = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            idx = int'(last) + 1 + i;
            if (idx >= COLS) idx -= COLS;
            if (!found && reqs[Y_W'(idx)]) begin
                found    = 1'b1;
                pick_col = Y_W'(idx);
            end
        end
    endfunction

    state_t                        r_state;
    logic [TS_W-1:0]               r_ts;
    logic [X_W-1:0]                r_row;
    logic [X_W-1:0]                r_last_row;
    logic [Y_W-1:0]                r_last_col;
    logic [COLS-1:0]               r_mask;
    logic [COLS-1:0][POL_W-1:0]    r_pol;

    evt_t                          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              r_wr_ptr;
    logic [PTR_W-1:0]              r_rd_ptr;
    logic [L_W-1:0]                r_level;

    logic [ROWS-1:0][COLS-1:0][POL_W-1:0] w_req;
    logic [ROWS-1:0][COLS-1:0]     w_pix_req;
    logic [ROWS-1:0][COLS-1:0]     w_gnt;
    logic [ROWS-1:0]               w_row_req;
    logic                          w_any_req;
    logic [X_W-1:0]                w_row_sel;
    logic [Y_W-1:0]                w_col_sel;
    logic [COLS-1:0]               w_mask_next;
    logic                          w_full;
    logic                          w_grant;
    logic                          w_marker_push;
    logic                          w_push;
    logic                          w_pop;
    evt_t                          w_push_evt;
    evt_t                          w_head;

    assign w_req = req_i;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_pix_req = '0;
        w_row_req = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_pix_req[r][c] = |w_req[r][c];
            end
            w_row_req[r] = |w_pix_req[r];
        end
    end

    assign w_any_req   = |w_row_req;
    assign w_row_sel   = pick_row(w_row_req, r_last_row);
    assign w_col_sel   = pick_col(r_mask, r_last_col);
    assign w_mask_next = r_mask & ~(COLS'(1) << w_col_sel);

    assign w_full  = (r_level == L_W'(FIFO_DEPTH));
    assign w_pop   = evt_valid_o && evt_ready_i;
    // A pending wrap marker takes the FIFO slot and suppresses this cycle's grant.
    assign w_grant = (r_state == S_COL_GRANT) && !w_full && !w_marker_push;
    assign w_push  = w_grant || w_marker_push;

    always_comb begin
        w_gnt = '0;
        if (w_grant) w_gnt[r_row][w_col_sel] = 1'b1;
    end
    assign gnt_o = w_gnt;

    always_comb begin
        w_push_evt    = '0;
        w_push_evt.ts = r_ts;
        if (!w_marker_push) begin
            w_push_evt.x   = r_row;
            w_push_evt.y   = w_col_sel;
            w_push_evt.pol = r_pol[w_col_sel];
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_ts <= '0;
        else           r_ts <= r_ts + TS_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_last_row <= X_W'(ROWS - 1);
            r_last_col <= Y_W'(COLS - 1);
            r_mask     <= '0;
            r_pol      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i && w_any_req) r_state <= S_ROW_ARB;
                end
                S_ROW_ARB: begin
                    if (w_any_req) begin
                        r_row      <= w_row_sel;
                        r_last_row <= w_row_sel;
                        r_mask     <= w_pix_req[w_row_sel];
                        r_pol      <= w_req[w_row_sel];
                        r_state    <= S_COL_GRANT;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_COL_GRANT: begin
                    if (w_grant) begin
                        r_mask     <= w_mask_next;
                        r_last_col <= w_col_sel;
                        if (w_mask_next == '0) r_state <= S_ROW_DONE;
                    end
                end
                S_ROW_DONE: begin
                    r_state <= (enable_i && w_any_req) ? S_ROW_ARB : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + L_W'(1);
                2'b01:   r_level <= r_level - L_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; r_level gates validity and the outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_evt;
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign evt_valid_o  = (r_level != '0);
    assign evt_x_o      = evt_valid_o ? w_head.x   : '0;
    assign evt_y_o      = evt_valid_o ? w_head.y   : '0;
    assign evt_pol_o    = evt_valid_o ? w_head.pol : '0;
    assign evt_ts_o     = evt_valid_o ? w_head.ts  : '0;
    assign fifo_level_o = r_level;
    assign busy_o       = (r_state != S_IDLE);

`ifdef EVT_TS_WRAP_MARKER_EN
    logic r_wrapped;
    logic r_marker_pend;
    logic r_wrap_mem [FIFO_DEPTH];

    // r_wrapped marks the cycle the counter reads 0; the marker becomes pending the cycle after.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wrapped     <= 1'b0;
            r_marker_pend <= 1'b0;
        end else begin
            r_wrapped <= (r_ts == '1);
            if (w_marker_push)  r_marker_pend <= 1'b0;
            else if (r_wrapped) r_marker_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_wrap_mem[r_wr_ptr] <= w_marker_push;
    end

    assign w_marker_push = r_marker_pend && !w_full;
    assign evt_wrap_o    = evt_valid_o && r_wrap_mem[r_rd_ptr];
`else
    assign w_marker_push = 1'b0;
    assign evt_wrap_o    = 1'b0;
`endif

endmodule

// File: tb/tb_event_arb_2d.sv
// Directed bench for event_arb_2d (4x4 array, TS_W=8, FIFO_DEPTH=4) with a queue-based event scoreboard.
module tb_event_arb_2d;

    localparam int ROWS = 4, COLS = 4, POL_W = 2, TS_W = 8, FIFO_DEPTH = 4, NPIX = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        enable_i;
    logic [31:0] req_i;
    logic [15:0] gnt_o;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic [1:0]  evt_x_o, evt_y_o, evt_pol_o;
    logic [7:0]  evt_ts_o;
    logic        evt_wrap_o;
    logic [2:0]  fifo_level_o;
    logic        busy_o;

    event_arb_2d #(.ROWS(ROWS), .COLS(COLS), .POL_W(POL_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .enable_i(enable_i), .req_i(req_i), .gnt_o(gnt_o),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_x_o(evt_x_o), .evt_y_o(evt_y_o),
        .evt_pol_o(evt_pol_o), .evt_ts_o(evt_ts_o), .evt_wrap_o(evt_wrap_o),
        .fifo_level_o(fifo_level_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp: value of the counter during the current cycle.
    logic [7:0] tb_ts;
    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) tb_ts <= 8'd0;
        else           tb_ts <= tb_ts + 8'd1;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [14:0] exp_q [$];
    int          g_idx [$];
    int          g_ts  [$];
    int          t0, t1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares every accepted head event with the oldest expectation.
    always @(negedge clk) begin
        if (reset_ni && evt_valid_o && evt_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL evt_unexpected: got x=%0d y=%0d pol=%0d ts=%0d wrap=%0d, expected no event",
                         evt_x_o, evt_y_o, evt_pol_o, evt_ts_o, evt_wrap_o);
            end else begin
                check("evt_fields", 64'({evt_x_o, evt_y_o, evt_pol_o, evt_ts_o, evt_wrap_o}), 64'(exp_q.pop_front()));
            end
        end
        if (reset_ni && gnt_o != 16'h0)
            check("gnt_onehot_busy", 64'({($countones(gnt_o) == 1), busy_o}), 64'(2'b11));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_pix(input int r, input int c, input logic [1:0] pol);
        req_i[(r * COLS + c) * POL_W +: POL_W] = pol;
    endtask

    task automatic exp_evt(input int x, input int y, input int pol, input int ts);
        exp_q.push_back({2'(x), 2'(y), 2'(pol), 8'(ts), 1'b0});
    endtask

    // Advance one cycle; granted pixels drop their request, and grants are logged with their cycle's timestamp.
    task automatic tick();
        for (int p = 0; p < NPIX; p++) begin
            if (gnt_o[p]) begin
                req_i[p * POL_W +: POL_W] = 2'b00;
                g_idx.push_back(p);
                g_ts.push_back(int'(tb_ts));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input string name, input int idx, input int ts);
        if (g_idx.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no grant, expected pixel %0d at ts %0d", name, idx, ts & 255);
        end else begin
            check({name, "_pix"}, 64'(g_idx.pop_front()), 64'(idx));
            check({name, "_ts"}, 64'(g_ts.pop_front()), 64'(ts & 255));
        end
    endtask

    task automatic no_more_gnts(input string name);
        check({name, "_extra_gnts"}, 64'(g_idx.size()), 64'(0));
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy_o && !evt_valid_o && exp_q.size() == 0) break;
            tick();
        end
        check({name, "_idle"}, 64'({busy_o, evt_valid_o}), 64'(0));
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        reset_ni    = 1'b0;
        enable_i    = 1'b0;
        req_i       = '0;
        evt_ready_i = 1'b1;
        exp_q.delete();
        g_idx.delete();
        g_ts.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
    endtask

    initial begin
        reset_ni    = 1'b1;
        enable_i    = 1'b0;
        req_i       = '0;
        evt_ready_i = 1'b1;
        #1 reset_ni = 1'b0;
        #1;
        check("rst_gnt",    64'(gnt_o), 64'(0));
        check("rst_valid",  64'(evt_valid_o), 64'(0));
        check("rst_level",  64'(fifo_level_o), 64'(0));
        check("rst_busy",   64'(busy_o), 64'(0));
        check("rst_fields", 64'({evt_x_o, evt_y_o, evt_pol_o, evt_ts_o, evt_wrap_o}), 64'(0));

        // Single pixel: latency and event contents.
        do_reset();
        t0 = int'(tb_ts);
        set_pix(2, 1, 2'b10);
        enable_i = 1'b1;
        exp_evt(2, 1, 2, t0 + 2);
        tick();
        check("t1_arb_busy", 64'(busy_o), 64'(1));
        check("t1_arb_nognt", 64'(gnt_o), 64'(0));
        tick();
        check("t1_gnt", 64'(gnt_o), 64'(16'h0200));
        tick();
        check("t1_valid", 64'(evt_valid_o), 64'(1));
        check("t1_level", 64'(fifo_level_o), 64'(1));
        tick();
        check("t1_back_idle", 64'(busy_o), 64'(0));
        expect_gnt("t1_g0", 9, t0 + 2);
        wait_idle("t1");
        no_more_gnts("t1");

        // Row then column round robin, with a guard cycle between rows.
        do_reset();
        t0 = int'(tb_ts);
        set_pix(1, 0, 2'b01); set_pix(1, 3, 2'b01); set_pix(3, 2, 2'b01);
        enable_i = 1'b1;
        exp_evt(1, 0, 1, t0 + 2); exp_evt(1, 3, 1, t0 + 3); exp_evt(3, 2, 1, t0 + 6);
        repeat (4) tick();
        check("t2_row_done_gap", 64'({busy_o, gnt_o}), 64'({1'b1, 16'h0000}));
        wait_idle("t2a");
        expect_gnt("t2a_g0", 4, t0 + 2);
        expect_gnt("t2a_g1", 7, t0 + 3);
        expect_gnt("t2a_g2", 14, t0 + 6);
        no_more_gnts("t2a");
        t1 = int'(tb_ts);
        set_pix(1, 0, 2'b01); set_pix(1, 3, 2'b01); set_pix(3, 2, 2'b01);
        exp_evt(1, 3, 1, t1 + 2); exp_evt(1, 0, 1, t1 + 3); exp_evt(3, 2, 1, t1 + 6);
        wait_idle("t2b");
        expect_gnt("t2b_g0", 7, t1 + 2);
        expect_gnt("t2b_g1", 4, t1 + 3);
        expect_gnt("t2b_g2", 14, t1 + 6);
        no_more_gnts("t2b");

        // Backpressure: FIFO fills at four, grants stall, then resume with nothing lost.
        do_reset();
        evt_ready_i = 1'b0;
        t0 = int'(tb_ts);
        set_pix(0, 0, 2'b01); set_pix(0, 2, 2'b10);
        set_pix(1, 1, 2'b11); set_pix(1, 2, 2'b01); set_pix(1, 3, 2'b10);
        set_pix(3, 0, 2'b11);
        enable_i = 1'b1;
        exp_evt(0, 0, 1, t0 + 2);  exp_evt(0, 2, 2, t0 + 3);
        exp_evt(1, 3, 2, t0 + 6);  exp_evt(1, 1, 3, t0 + 7);
        exp_evt(1, 2, 1, t0 + 11); exp_evt(3, 0, 3, t0 + 14);
        repeat (8) tick();
        for (int k = 0; k < 3; k++) begin
            check("t3_full_level", 64'(fifo_level_o), 64'(4));
            check("t3_full_nognt", 64'(gnt_o), 64'(0));
            if (k < 2) tick();
        end
        evt_ready_i = 1'b1;
        tick();
        check("t3_level_after_pop", 64'(fifo_level_o), 64'(3));
        wait_idle("t3");
        expect_gnt("t3_g0", 0, t0 + 2);
        expect_gnt("t3_g1", 2, t0 + 3);
        expect_gnt("t3_g2", 7, t0 + 6);
        expect_gnt("t3_g3", 5, t0 + 7);
        expect_gnt("t3_g4", 6, t0 + 11);
        expect_gnt("t3_g5", 12, t0 + 14);
        no_more_gnts("t3");

        // Asynchronous reset in the middle of a row, then pointers back at row 0 / column 0.
        do_reset();
        evt_ready_i = 1'b0;
        for (int c = 0; c < COLS; c++) set_pix(0, c, 2'b01);
        enable_i = 1'b1;
        repeat (4) tick();
        check("t4_level_pre", 64'(fifo_level_o), 64'(2));
        check("t4_busy_pre", 64'(busy_o), 64'(1));
        reset_ni = 1'b0;
        #1;
        check("t4_rst_valid", 64'(evt_valid_o), 64'(0));
        check("t4_rst_level", 64'(fifo_level_o), 64'(0));
        check("t4_rst_busy_gnt", 64'({busy_o, gnt_o}), 64'(0));
        do_reset();
        t1 = int'(tb_ts);
        set_pix(0, 1, 2'b11); set_pix(0, 3, 2'b11); set_pix(2, 1, 2'b11);
        enable_i = 1'b1;
        exp_evt(0, 1, 3, t1 + 2); exp_evt(0, 3, 3, t1 + 3); exp_evt(2, 1, 3, t1 + 6);
        wait_idle("t4");
        expect_gnt("t4_g0", 1, t1 + 2);
        expect_gnt("t4_g1", 3, t1 + 3);
        expect_gnt("t4_g2", 9, t1 + 6);
        no_more_gnts("t4");

        // Dropping enable mid-row finishes the row, then parks in IDLE.
        do_reset();
        t0 = int'(tb_ts);
        set_pix(1, 0, 2'b01); set_pix(1, 1, 2'b10); set_pix(1, 2, 2'b11); set_pix(2, 3, 2'b01);
        enable_i = 1'b1;
        exp_evt(1, 0, 1, t0 + 2); exp_evt(1, 1, 2, t0 + 3); exp_evt(1, 2, 3, t0 + 4);
        tick();
        tick();
        check("t5_first_gnt", 64'(gnt_o), 64'(16'h0010));
        enable_i = 1'b0;
        repeat (4) tick();
        check("t5_idle_after_row", 64'(busy_o), 64'(0));
        tick();
        tick();
        check("t5_other_row_waits", 64'({busy_o, gnt_o}), 64'(0));
        expect_gnt("t5_g0", 4, t0 + 2);
        expect_gnt("t5_g1", 5, t0 + 3);
        expect_gnt("t5_g2", 6, t0 + 4);
        no_more_gnts("t5a");
        t1 = int'(tb_ts);
        enable_i = 1'b1;
        exp_evt(2, 3, 1, t1 + 2);
        wait_idle("t5");
        expect_gnt("t5_g3", 11, t1 + 2);
        no_more_gnts("t5b");

        // Burst across the 255 -> 0 timestamp wrap: no marker in the default build, no grant delay.
        do_reset();
        for (int i = 0; i < 300 && tb_ts != 8'd252; i++) tick();
        t0 = int'(tb_ts);
        for (int c = 0; c < COLS; c++) begin
            set_pix(0, c, 2'b10);
            exp_evt(0, c, 2, t0 + 2 + c);
        end
        enable_i = 1'b1;
        repeat (4) tick();
        check("t6_gnt_at_wrap", 64'(gnt_o), 64'(16'h0004));
        wait_idle("t6");
        for (int c = 0; c < COLS; c++) expect_gnt("t6_g", c, t0 + 2 + c);
        no_more_gnts("t6");
        repeat (4) tick();
        check("t6_no_marker", 64'({evt_valid_o, fifo_level_o}), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/event_arb_2d.md
EVENT_ARB_2D -- requirements
Module: event_arb_2d

Interface
REQ-001 Parameter ROWS, default 4, pixel rows (>=2).
REQ-002 Parameter COLS, default 4, pixel columns (>=2).
REQ-003 Parameter POL_W, default 2, polarity bits per pixel.
REQ-004 Parameter TS_W, default 32, timestamp width.
REQ-005 Parameter FIFO_DEPTH, default 8, output event FIFO entries (power of 2, >=2).
REQ-006 Derived widths: X_W = max(1,clog2(ROWS)), Y_W = max(1,clog2(COLS)), L_W = clog2(FIFO_DEPTH)+1.
REQ-007 clk_i  in  1  single clock, all logic on rising edge.
REQ-008 reset_ni  in  1  asynchronous active-low reset.
REQ-009 enable_i  in  1  permits starting new row arbitrations.
REQ-010 req_i  in  ROWS*COLS*POL_W  pixel request polarity bits, pixel (r,c) at bits [(r*COLS+c)*POL_W +: POL_W]; pixel requests when any bit set.
REQ-011 gnt_o  out  ROWS*COLS  one-cycle one-hot pixel acknowledge, bit r*COLS+c.
REQ-012 evt_valid_o  out  1  FIFO head valid.
REQ-013 evt_ready_i  in  1  consumer accepts head when evt_valid_o=1.
REQ-014 evt_x_o / evt_y_o / evt_pol_o / evt_ts_o / evt_wrap_o  out  X_W / Y_W / POL_W / TS_W / 1  head event fields.
REQ-015 fifo_level_o  out  L_W  current FIFO occupancy.
REQ-016 busy_o  out  1  high when FSM not IDLE.

Function
REQ-017 Free-running TS_W-bit counter SHALL increment every cycle, wrapping 2^TS_W-1 -> 0.
REQ-018 FSM states: IDLE, ROW_ARB, COL_GRANT, ROW_DONE.
REQ-019 IDLE -> ROW_ARB when enable_i=1 and any pixel requests; else stay.
REQ-020 ROW_ARB (one cycle): round-robin pick among requesting rows, starting at row after last granted row; latch row index, per-column request mask, and polarity bits of that row; -> COL_GRANT.
REQ-021 COL_GRANT: each cycle FIFO not full, grant one masked column, round-robin from column after last granted column (pointer persists across rows); pulse gnt_o, push {x,y,latched pol,counter value of that cycle,wrap=0}, clear mask bit.
REQ-022 COL_GRANT with FIFO full: no grant, no gnt_o, hold state and mask.
REQ-023 Last mask bit granted -> ROW_DONE (one guard cycle, no grant, lets pixels drop requests).
REQ-024 ROW_DONE -> ROW_ARB if enable_i=1 and any request, else IDLE.
REQ-025 enable_i low during COL_GRANT SHALL NOT abort the row; latched row completes, then IDLE via ROW_DONE.
REQ-026 Latency: request with enable_i=1 in IDLE at cycle n -> ROW_ARB n+1, first gnt_o n+2, evt_valid_o n+3.
REQ-027 FIFO: push and pop same cycle allowed when not empty; level unchanged; pop only when evt_valid_o&&evt_ready_i; pointers wrap modulo FIFO_DEPTH; no overwrite, no event loss.
REQ-028 Output fields SHALL be stable while evt_valid_o=1 and evt_ready_i=0.
REQ-029 At most one gnt_o bit high per cycle; gnt_o always zero outside COL_GRANT.

Reset
REQ-030 reset_ni=0 SHALL immediately clear FSM to IDLE, counter to 0, FIFO empty, fifo_level_o=0, all outputs 0, row/column pointers so row 0 and column 0 have first priority.
REQ-031 Reset mid-row SHALL discard latched mask; in-flight events lost.

Configuration
REQ-032 Macro EVT_TS_WRAP_MARKER_EN defined: on counter wrap to 0 set pending flag; next cycle FIFO not full, push marker {x=0,y=0,pol=0,ts=counter,wrap=1} with priority, suppressing any grant that cycle; flag cleared on push.
REQ-033 Macro undefined: no marker logic, evt_wrap_o tied 0.

Verification (ROWS=4,COLS=4,POL_W=2,TS_W=8,FIFO_DEPTH=4)
REQ-034 Pixel (2,1)=2'b10, enable_i=1 at cycle 10 in IDLE -> gnt_o bit 9 pulse cycle 12; event x=2,y=1,pol=2,ts=12 valid cycle 13.
REQ-035 Pixels (1,0),(1,3),(3,2) together -> grant order (1,0),(1,3),(3,2) with ROW_DONE between rows; re-request all -> row 1 served before row 3, row order restarts after row 3.
REQ-036 evt_ready_i=0, six pixels requesting -> four events stored, fifo_level_o=4, gnt_o stops; evt_ready_i=1 -> remaining two granted, six events in order, none lost.
REQ-037 reset_ni low during COL_GRANT with 2 events queued -> evt_valid_o=0, fifo_level_o=0, busy_o=0 same cycle; after release, new request served from row 0 priority.
REQ-038 Macro defined, counter 255->0 during burst -> one wrap=1 marker with ts=1 inserted, adjacent grant delayed one cycle; macro undefined -> no marker.
REQ-039 enable_i dropped in COL_GRANT of row with 3 requests -> all 3 granted, ROW_DONE, IDLE, other rows wait.
